// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with an integrated trap sequencer.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   csr_op_i/addr/wdata CSR access (00 none, 01 write, 10 set, 11 clear)
//   csr_rdata_o        combinational pre-update read value (0 when illegal)
//   csr_illegal_o      combinational illegal-access flag
//   instr_retire_i     increments minstret
//   exc_*              synchronous exception (cause, pc, tval)
//   int_req_o          an enabled interrupt is pending
//   int_take_i         pipeline accepts the interrupt (resume pc on exc_pc_i)
//   mret_i             return from trap
//   irq_*_i            asynchronous interrupt lines
//   redirect_*_o       registered one-cycle fetch redirect
module csr_trap_unit #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] HARTID      = '0,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter int              SYNC_STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            instr_retire_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  output logic            int_req_o,
  input  logic            int_take_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_soft_i,
  input  logic            irq_timer_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

  // Synchroniser bit order {ext, timer, soft}
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic [2:0]      r_mip;
  logic            r_st_mie, r_st_mpie;
  logic [XLEN-1:0] r_mie, r_mtvec, r_mepc, r_mcause, r_mtval, r_mcycle, r_minstret;
  logic            r_redir_vld;
  logic [XLEN-1:0] r_redir_pc;

  logic [XLEN-1:0] w_mstatus, w_mip, w_old, w_new, w_pend, w_cause, w_base;
  logic            w_supp, w_illegal, w_take_int, w_trap, w_mret, w_wr, w_vec;
  logic [3:0]      w_code;

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_st_mpie;
    w_mstatus[3]     = r_st_mie;
    w_mip            = '0;
    w_mip[11]        = r_mip[2];
    w_mip[7]         = r_mip[1];
    w_mip[3]         = r_mip[0];
    w_supp           = 1'b1;
    w_old            = '0;
    case (csr_addr_i)
      12'h300: w_old = w_mstatus;
      12'h304: w_old = r_mie;
      12'h305: w_old = r_mtvec;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h343: w_old = r_mtval;
      12'h344: w_old = w_mip;
      12'hB00: w_old = r_mcycle;
      12'hB02: w_old = r_minstret;
      12'hF14: w_old = HARTID;
      default: w_supp = 1'b0;
    endcase
    // Read-only space is addr[11:10]==11; a plain read there is fine
    w_illegal = !w_supp || (csr_addr_i[11:10] == 2'b11 && csr_op_i != 2'b00);
    case (csr_op_i)
      2'b01:   w_new = csr_wdata_i;
      2'b10:   w_new = w_old | csr_wdata_i;
      default: w_new = w_old & ~csr_wdata_i;
    endcase
  end

  assign csr_rdata_o   = w_illegal ? '0 : w_old;
  assign csr_illegal_o = w_illegal;

  assign w_pend    = w_mip & r_mie;
  assign int_req_o = r_st_mie & (|w_pend);
  // Fixed arbitration: MEI > MSI > MTI
  assign w_code    = w_pend[11] ? 4'd11 : (w_pend[3] ? 4'd3 : 4'd7);

  // Event priority: exception > interrupt take > mret > CSR write
  assign w_take_int = int_take_i && int_req_o && !exc_valid_i;
  assign w_trap     = exc_valid_i || w_take_int;
  assign w_mret     = mret_i && !w_trap;
  assign w_wr       = (csr_op_i != 2'b00) && !w_illegal && !w_trap && !w_mret;

  assign w_base = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_vec  = (r_mtvec[1:0] == 2'b01);

  always_comb begin
    w_cause         = '0;
    w_cause[XLEN-1] = w_take_int;
    w_cause[3:0]    = w_take_int ? w_code : exc_cause_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_mip       <= '0;
      r_st_mie    <= 1'b0;
      r_st_mpie   <= 1'b0;
      r_mie       <= '0;
      r_mtvec     <= MTVEC_RST;
      r_mepc      <= '0;
      r_mcause    <= '0;
      r_mtval     <= '0;
      r_mcycle    <= '0;
      r_minstret  <= '0;
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      r_sync[0] <= {irq_ext_i, irq_timer_i, irq_soft_i};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_mip       <= r_sync[SYNC_STAGES-1];
      r_mcycle    <= r_mcycle + 1'b1;
      r_minstret  <= r_minstret + XLEN'(instr_retire_i);
      r_redir_vld <= w_trap || w_mret;

      if (w_trap) begin
        r_mepc     <= exc_pc_i & ~XLEN'(3);
        r_mcause   <= w_cause;
        r_mtval    <= w_take_int ? '0 : exc_tval_i;
        r_st_mpie  <= r_st_mie;
        r_st_mie   <= 1'b0;
        r_redir_pc <= (w_take_int && w_vec) ? w_base + XLEN'({w_code, 2'b00}) : w_base;
      end else if (w_mret) begin
        r_st_mie   <= r_st_mpie;
        r_st_mpie  <= 1'b1;
        r_redir_pc <= r_mepc;
      end else if (w_wr) begin
        // Writes to mip and unknown-but-legal bits fall through unchanged
        case (csr_addr_i)
          12'h300: begin
            r_st_mie  <= w_new[3];
            r_st_mpie <= w_new[7];
          end
          12'h304: r_mie      <= w_new & MIE_MASK;
          12'h305: r_mtvec    <= w_new[1] ? {w_new[XLEN-1:2], 2'b00} : w_new;
          12'h341: r_mepc     <= {w_new[XLEN-1:2], 2'b00};
          12'h342: r_mcause   <= w_new;
          12'h343: r_mtval    <= w_new;
          12'hB00: r_mcycle   <= w_new;
          12'hB02: r_minstret <= w_new;
          default: ;
        endcase
      end
    end
  end

  assign redirect_valid_o = r_redir_vld;
  assign redirect_pc_o    = r_redir_pc;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: the driver pushes expected values into
// queues as it issues stimulus; a negedge monitor pops and compares.
module tb_csr_trap_unit;
  localparam int XLEN = 64;
  localparam int SS   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      csr_op_i = '0;
  logic [11:0]     csr_addr_i = '0;
  logic [XLEN-1:0] csr_wdata_i = '0;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;
  logic            instr_retire_i = 1'b0;
  logic            exc_valid_i = 1'b0;
  logic [3:0]      exc_cause_i = '0;
  logic [XLEN-1:0] exc_pc_i = '0;
  logic [XLEN-1:0] exc_tval_i = '0;
  logic            int_req_o;
  logic            int_take_i = 1'b0;
  logic            mret_i = 1'b0;
  logic            irq_ext_i = 1'b0, irq_soft_i = 1'b0, irq_timer_i = 1'b0;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;

  csr_trap_unit #(.XLEN(XLEN), .HARTID(64'd5), .MTVEC_RST(64'h100), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .instr_retire_i(instr_retire_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
    .exc_tval_i(exc_tval_i), .int_req_o(int_req_o), .int_take_i(int_take_i),
    .mret_i(mret_i), .irq_ext_i(irq_ext_i), .irq_soft_i(irq_soft_i),
    .irq_timer_i(irq_timer_i), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  // probe kinds: 0 rdata, 1 illegal, 2 int_req, 3 redirect_valid
  logic [63:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  logic [63:0] rdr_q[$];
  logic        probe = 1'b0;

  always @(negedge clk) begin
    logic [63:0] act, e;
    int k;
    string n;
    if (probe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow act=empty exp=entry");
      end else begin
        e = exp_q.pop_front(); k = kind_q.pop_front(); n = name_q.pop_front();
        case (k)
          0:       act = csr_rdata_o;
          1:       act = 64'(csr_illegal_o);
          2:       act = 64'(int_req_o);
          default: act = 64'(redirect_valid_o);
        endcase
        if (act !== e) begin
          failures++;
          $display("FAIL %s act=%h exp=%h", n, act, e);
        end
      end
    end
    if (redirect_valid_o) begin
      checks++;
      if (rdr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_redirect act=%h exp=none", redirect_pc_o);
      end else begin
        e = rdr_q.pop_front();
        if (redirect_pc_o !== e) begin
          failures++;
          $display("FAIL redirect_pc act=%h exp=%h", redirect_pc_o, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    csr_op_i = 0; csr_addr_i = 0; csr_wdata_i = 0; instr_retire_i = 0;
    exc_valid_i = 0; int_take_i = 0; mret_i = 0; probe = 0;
  endtask

  task automatic chk(input int k, input logic [63:0] e, input string n);
    probe = 1; kind_q.push_back(k); exp_q.push_back(e); name_q.push_back(n);
    cyc();
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] e, input string n);
    csr_op_i = 0; csr_addr_i = a;
    chk(0, e, n);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    cyc();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    rd(12'h300, 64'h1800, "rst_mstatus");
    rd(12'hF14, 64'd5, "rst_mhartid");
    rd(12'h305, 64'h100, "rst_mtvec");
    rd(12'h342, 64'h0, "rst_mcause");
    chk(2, 0, "rst_int_req");
    csr_addr_i = 12'h7C0; chk(1, 1, "ill_unsupported");
    rd(12'h7C0, 64'h0, "ill_rdata_zero");

    // WARL masking and set/clear
    wr(2'b01, 12'h300, 64'hFFFF_FFFF);
    rd(12'h300, 64'h1888, "mstatus_warl");
    wr(2'b10, 12'h304, 64'h888);
    wr(2'b11, 12'h304, 64'h8);
    rd(12'h304, 64'h880, "mie_set_clr");
    wr(2'b01, 12'h304, 64'hFFFF);
    rd(12'h304, 64'h888, "mie_warl");
    wr(2'b01, 12'h305, 64'h2003);
    rd(12'h305, 64'h2000, "mtvec_mode_warl");
    csr_op_i = 2'b01; csr_addr_i = 12'h344; csr_wdata_i = '1; chk(1, 0, "mip_wr_legal");
    rd(12'h344, 64'h0, "mip_wr_ignored");

    // Interrupt: MIE=1, mie=0x888, vectored mtvec
    wr(2'b01, 12'h300, 64'h8);
    wr(2'b01, 12'h305, 64'h1001);
    irq_timer_i = 1; irq_ext_i = 1;
    for (int i = 0; i < SS + 1; i++) chk(2, 0, "int_req_latency_lo");
    chk(2, 1, "int_req_latency_hi");
    int_take_i = 1; exc_pc_i = 64'h8000_0102; rdr_q.push_back(64'h102C);
    irq_timer_i = 0; irq_ext_i = 0;
    cyc();
    rd(12'h342, (64'h1 << 63) | 64'd11, "int_mcause");
    rd(12'h341, 64'h8000_0100, "int_mepc");
    rd(12'h300, 64'h1880, "int_mstatus");
    rd(12'h343, 64'h0, "int_mtval");
    chk(2, 0, "int_req_after_take");

    // Exception beats mret and a mepc write in the same cycle
    repeat (4) cyc();
    exc_valid_i = 1; exc_cause_i = 4'd2; exc_tval_i = 64'hDEAD; exc_pc_i = 64'h4000_0006;
    mret_i = 1; csr_op_i = 2'b01; csr_addr_i = 12'h341; csr_wdata_i = 64'h1234;
    rdr_q.push_back(64'h1000);
    cyc();
    rd(12'h341, 64'h4000_0004, "exc_mepc");
    rd(12'h342, 64'h2, "exc_mcause");
    rd(12'h343, 64'hDEAD, "exc_mtval");
    rd(12'h300, 64'h1800, "exc_mstatus");

    // mret with MPIE=1
    wr(2'b01, 12'h300, 64'h80);
    mret_i = 1; rdr_q.push_back(64'h4000_0004);
    cyc();
    rd(12'h300, 64'h1888, "mret_mstatus");
    chk(2, 0, "int_req_none_pending");

    // Counters
    wr(2'b01, 12'hB00, '1);
    rd(12'hB00, '1, "mcycle_written");
    rd(12'hB00, 64'h0, "mcycle_wrap");
    rd(12'hB00, 64'h1, "mcycle_inc");
    wr(2'b01, 12'hB02, 64'h0);
    instr_retire_i = 1; cyc();
    cyc();
    instr_retire_i = 1; cyc();
    instr_retire_i = 1; cyc();
    rd(12'hB02, 64'd3, "minstret_count");

    // Read-only write
    csr_op_i = 2'b01; csr_addr_i = 12'hF14; csr_wdata_i = 64'hFF; chk(1, 1, "ill_hartid_wr");
    rd(12'hF14, 64'd5, "mhartid_unchanged");

    // Reset on the trap edge cancels the redirect
    exc_valid_i = 1; exc_cause_i = 4'd1; rst_n = 0;
    cyc();
    rst_n = 1;
    chk(3, 0, "redir_cancelled");
    rd(12'h300, 64'h1800, "post_rst_mstatus");

    repeat (3) cyc();
    checks++;
    if (rdr_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained act=%0d exp=0", rdr_q.size() + exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
